// File: rtl/serial_logic_unit_if.sv
// Handshake and result bundle for serial_logic_unit: operand/opcode request side
// plus the serial bit stream and parallel result side.
interface serial_logic_unit_if #(
    parameter int N = 8
) ();
    localparam int CW = $clog2(N);

    logic          start;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic [1:0]    op;
    logic          busy;
    logic          bit_valid;
    logic          bit_out;
    logic [CW-1:0] bit_idx;
    logic [N-1:0]  out;
    logic          done;

    modport master (
        output start, a, b, op,
        input  busy, bit_valid, bit_out, bit_idx, out, done
    );

    modport slave (
        input  start, a, b, op,
        output busy, bit_valid, bit_out, bit_idx, out, done
    );
endinterface

// File: rtl/serial_logic_unit.sv
// Bit-serial bitwise logic unit: captures two N-bit operands and an opcode, then
// evaluates one result bit per clock LSB first, streaming it and assembling a word.
module serial_logic_unit #(
    parameter int N   = 8,
    parameter int OPW = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_logic_unit_if.slave bus
);
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_r;
    logic [N-1:0]   a_sh_r;
    logic [N-1:0]   b_sh_r;
    logic [OPW-1:0] op_r;
    logic [CW-1:0]  cnt_r;
    logic [N-1:0]   out_r;
    logic           busy_r;
    logic           bit_valid_r;
    logic           done_r;
    logic           bit_s;

    // One result bit for the given opcode; NAND is the inverted AND.
    function automatic logic op_eval(input logic [OPW-1:0] opc, input logic x, input logic y);
        logic r;
        case (opc)
            2'b00:   r = x & y;
            2'b01:   r = x | y;
            2'b10:   r = x ^ y;
            2'b11:   r = ~(x & y);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Serial bit is presented only while the word is being evaluated.
    always_comb begin
        bit_s = 1'b0;
        if (bit_valid_r) begin
            bit_s = op_eval(op_r, a_sh_r[0], b_sh_r[0]);
        end else begin
            bit_s = 1'b0;
        end
    end

    // Control FSM with operand shifters, bit counter and result assembly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            a_sh_r      <= '0;
            b_sh_r      <= '0;
            op_r        <= '0;
            cnt_r       <= '0;
            out_r       <= '0;
            busy_r      <= 1'b0;
            bit_valid_r <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    cnt_r  <= '0;
                    if (bus.start) begin
                        a_sh_r      <= bus.a;
                        b_sh_r      <= bus.b;
                        op_r        <= bus.op;
                        out_r       <= '0;
                        busy_r      <= 1'b1;
                        bit_valid_r <= 1'b1;
                        state_r     <= RUN;
                    end else begin
                        busy_r      <= 1'b0;
                        bit_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                RUN: begin
                    out_r[cnt_r] <= bit_s;
                    a_sh_r       <= {1'b0, a_sh_r[N-1:1]};
                    b_sh_r       <= {1'b0, b_sh_r[N-1:1]};
                    if (cnt_r == LAST_IDX) begin
                        // Counter returns to zero so bit_idx reads 0 outside RUN.
                        cnt_r       <= '0;
                        busy_r      <= 1'b0;
                        bit_valid_r <= 1'b0;
                        done_r      <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        cnt_r   <= cnt_r + CW'(1);
                        state_r <= RUN;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    cnt_r       <= '0;
                    busy_r      <= 1'b0;
                    bit_valid_r <= 1'b0;
                    done_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.bit_valid = bit_valid_r;
    assign bus.bit_out   = bit_s;
    assign bus.bit_idx   = cnt_r;
    assign bus.out       = out_r;
    assign bus.done      = done_r;
endmodule

// File: tb/tb_serial_logic_unit.sv
// Directed bench for serial_logic_unit: an 8-bit instance driven from a vector
// table plus hand-written sequences, and a 5-bit instance for the odd width.
module tb_serial_logic_unit;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   cyc;
    int   done_cyc1;
    int   done_cyc2;

    serial_logic_unit_if #(.N(8)) bus8 ();
    serial_logic_unit_if #(.N(5)) bus5 ();

    serial_logic_unit #(.N(8), .OPW(2)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    serial_logic_unit #(.N(5), .OPW(2)) dut5 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
        logic [7:0] exp;
        logic       scramble;
    } vec_t;

    vec_t vecs[7];

    function automatic logic [7:0] gold(input logic [1:0] opc, input logic [7:0] x, input logic [7:0] y);
        case (opc)
            2'b00:   return x & y;
            2'b01:   return x | y;
            2'b10:   return x ^ y;
            default: return ~(x & y);
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Checks the N RUN cycles following an accepted start edge.
    task automatic stream8(input string tag, input logic [7:0] exp, input logic scramble);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("%s busy[%0d]", tag, i), 32'(bus8.busy), 32'd1);
            chk($sformatf("%s valid[%0d]", tag, i), 32'(bus8.bit_valid), 32'd1);
            chk($sformatf("%s idx[%0d]", tag, i), 32'(bus8.bit_idx), 32'(i));
            chk($sformatf("%s bit[%0d]", tag, i), 32'(bus8.bit_out), 32'(exp[i]));
            chk($sformatf("%s nodone[%0d]", tag, i), 32'(bus8.done), 32'd0);
            if (scramble) begin
                bus8.a  = 8'($urandom);
                bus8.b  = 8'($urandom);
                bus8.op = 2'($urandom);
            end
        end
    endtask

    task automatic check_done8(input string tag, input logic [7:0] exp);
        @(negedge clk);
        chk({tag, " done"}, 32'(bus8.done), 32'd1);
        chk({tag, " busy0"}, 32'(bus8.busy), 32'd0);
        chk({tag, " valid0"}, 32'(bus8.bit_valid), 32'd0);
        chk({tag, " bit0"}, 32'(bus8.bit_out), 32'd0);
        chk({tag, " idx0"}, 32'(bus8.bit_idx), 32'd0);
        chk({tag, " out"}, 32'(bus8.out), 32'(exp));
    endtask

    task automatic word8(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] op, input logic [7:0] exp, input logic scramble);
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.a     = a;
        bus8.b     = b;
        bus8.op    = op;
        @(posedge clk);
        #1 bus8.start = 1'b0;
        stream8(tag, exp, scramble);
        check_done8(tag, exp);
        chk({tag, " gold"}, 32'(bus8.out), 32'(gold(op, a, b)));
        @(negedge clk);
        chk({tag, " done1cyc"}, 32'(bus8.done), 32'd0);
        chk({tag, " hold"}, 32'(bus8.out), 32'(exp));
    endtask

    initial begin
        logic [4:0] exp5;
        total = 0;
        bad   = 0;
        cyc   = 0;
        rst_n = 1'b0;
        bus8.start = 1'b0; bus8.a = 8'h00; bus8.b = 8'h00; bus8.op = 2'b00;
        bus5.start = 1'b0; bus5.a = 5'h00; bus5.b = 5'h00; bus5.op = 2'b00;

        vecs[0] = '{a: 8'hA5, b: 8'h3C, op: 2'b00, exp: 8'h24, scramble: 1'b0};
        vecs[1] = '{a: 8'hF0, b: 8'hCC, op: 2'b00, exp: 8'hC0, scramble: 1'b0};
        vecs[2] = '{a: 8'hF0, b: 8'hCC, op: 2'b01, exp: 8'hFC, scramble: 1'b0};
        vecs[3] = '{a: 8'hF0, b: 8'hCC, op: 2'b10, exp: 8'h3C, scramble: 1'b0};
        vecs[4] = '{a: 8'hF0, b: 8'hCC, op: 2'b11, exp: 8'h3F, scramble: 1'b0};
        vecs[5] = '{a: 8'h5A, b: 8'hC3, op: 2'b10, exp: 8'h99, scramble: 1'b1};
        vecs[6] = '{a: 8'h00, b: 8'h00, op: 2'b11, exp: 8'hFF, scramble: 1'b0};

        #2;
        chk("rst busy", 32'(bus8.busy), 32'd0);
        chk("rst valid", 32'(bus8.bit_valid), 32'd0);
        chk("rst out", 32'(bus8.out), 32'd0);
        chk("rst done", 32'(bus8.done), 32'd0);
        chk("rst idx5", 32'(bus5.bit_idx), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 7; v++) begin
            word8($sformatf("vec%0d", v), vecs[v].a, vecs[v].b, vecs[v].op, vecs[v].exp, vecs[v].scramble);
        end

        // Back-to-back with start held high the whole time.
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'h01; bus8.b = 8'h01; bus8.op = 2'b00;
        @(posedge clk);
        stream8("b2b1", 8'h01, 1'b0);
        check_done8("b2b1", 8'h01);
        done_cyc1 = cyc;
        bus8.a = 8'h80; bus8.b = 8'h80;
        stream8("b2b2", 8'h80, 1'b0);
        check_done8("b2b2", 8'h80);
        done_cyc2 = cyc;
        chk("b2b spacing", 32'(done_cyc2 - done_cyc1), 32'd9);
        bus8.start = 1'b0;
        @(negedge clk);
        chk("b2b idle busy", 32'(bus8.busy), 32'd0);
        chk("b2b idle done", 32'(bus8.done), 32'd0);
        chk("b2b idle out", 32'(bus8.out), 32'h80);

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.op = 2'b00;
        @(posedge clk);
        #1 bus8.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre-rst busy", 32'(bus8.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid-rst busy", 32'(bus8.busy), 32'd0);
        chk("mid-rst valid", 32'(bus8.bit_valid), 32'd0);
        chk("mid-rst bit", 32'(bus8.bit_out), 32'd0);
        chk("mid-rst idx", 32'(bus8.bit_idx), 32'd0);
        chk("mid-rst out", 32'(bus8.out), 32'd0);
        chk("mid-rst done", 32'(bus8.done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("post-rst nodone[%0d]", i), 32'(bus8.done), 32'd0);
            chk($sformatf("post-rst idle[%0d]", i), 32'(bus8.busy), 32'd0);
        end
        word8("after-rst", 8'h0F, 8'hFF, 2'b00, 8'h0F, 1'b0);

        // Odd width: 5-bit XOR.
        exp5 = 5'h0A;
        @(negedge clk);
        bus5.start = 1'b1; bus5.a = 5'h1F; bus5.b = 5'h15; bus5.op = 2'b10;
        @(posedge clk);
        #1 bus5.start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("n5 valid[%0d]", i), 32'(bus5.bit_valid), 32'd1);
            chk($sformatf("n5 idx[%0d]", i), 32'(bus5.bit_idx), 32'(i));
            chk($sformatf("n5 bit[%0d]", i), 32'(bus5.bit_out), 32'(exp5[i]));
            chk($sformatf("n5 nodone[%0d]", i), 32'(bus5.done), 32'd0);
        end
        @(negedge clk);
        chk("n5 done", 32'(bus5.done), 32'd1);
        chk("n5 valid0", 32'(bus5.bit_valid), 32'd0);
        chk("n5 idx0", 32'(bus5.bit_idx), 32'd0);
        chk("n5 out", 32'(bus5.out), 32'h0A);
        @(negedge clk);
        chk("n5 done1cyc", 32'(bus5.done), 32'd0);
        chk("n5 hold", 32'(bus5.out), 32'h0A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
